// File: rtl/data_mem_responder.sv
// Fixed-latency single-port data memory responder: accepts one read or write,
// waits LATENCY edges, then pulses rsp_valid for one cycle.
module data_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  dbgState
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // WAIT spans LATENCY-1 edges; the counter reaching zero marks the edge into RESP.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  // Handshake: a request is accepted on a rising edge where req_en=1 and ready=1;
  // rsp_valid is a single-cycle pulse, and req_en while ready=0 is dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateE;

  stateE                 state, nextState;
  logic [3:0]            cnt, nextCnt;
  logic                  accept, doAccess;
  logic                  latWr;
  logic [DEPTH_LOG2-1:0] latIdx;
  logic [15:0]           latData;
  logic                  accWr;
  logic [DEPTH_LOG2-1:0] accIdx, reqIdx;
  logic [15:0]           accData;
  logic                  unusedAddrBits;
  logic [15:0]           mem [DEPTH];

  // Bit 0 and bits above the word index are don't-care; upper bits alias.
  assign reqIdx         = req_addr[DEPTH_LOG2:1];
  assign unusedAddrBits = ^req_addr;

  assign accept    = req_en && (state == IDLE);
  assign ready     = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign dbgState  = state;

  // With LATENCY==1 the access happens on the acceptance edge, before the latches hold it.
  assign accWr   = (state == IDLE) ? req_wr    : latWr;
  assign accIdx  = (state == IDLE) ? reqIdx    : latIdx;
  assign accData = (state == IDLE) ? req_wdata : latData;

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    doAccess  = 1'b0;
    case (state)
      IDLE: begin
        if (req_en) begin
          if (LATENCY == 1) begin
            nextState = RESP;
            doAccess  = 1'b1;
          end else begin
            nextState = WAIT;
            nextCnt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          nextState = RESP;
          doAccess  = 1'b1;
        end else begin
          nextCnt = cnt - 4'd1;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      latWr     <= 1'b0;
      latIdx    <= '0;
      latData   <= 16'h0000;
      rsp_rdata <= 16'h0000;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (accept) begin
        latWr   <= req_wr;
        latIdx  <= reqIdx;
        latData <= req_wdata;
      end
      // Read data lives only in the RESP cycle; every other cycle it is zero.
      if (doAccess && !accWr) rsp_rdata <= mem[accIdx];
      else                    rsp_rdata <= 16'h0000;
    end
  end

  // Array is never cleared; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (!rst && doAccess && accWr) mem[accIdx] <= accData;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 4 and 1) checked every
// cycle against a transaction-level model of acceptance timing and memory contents.
module tb_data_mem_responder;

  localparam int DEPTH_LOG2 = 10;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        reqEn     [2];
  logic        reqWr     [2];
  logic [15:0] reqAddr   [2];
  logic [15:0] reqWdata  [2];
  logic        ready     [2];
  logic        rspValid  [2];
  logic [15:0] rspRdata  [2];
  logic [1:0]  dbgState  [2];

  int nAsserts = 0;
  int nFails   = 0;

  // model state: cycles elapsed since acceptance (0 = idle) and the pending op
  int          lat      [2] = '{4, 1};
  int          sinceAcc [2];
  logic        pWr      [2];
  int          pIdx     [2];
  logic [15:0] pData    [2];
  logic [15:0] modelMem [int];

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(4), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .rst(rst[0]), .req_en(reqEn[0]), .req_wr(reqWr[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .ready(ready[0]), .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]),
    .dbgState(dbgState[0])
  );

  data_mem_responder #(.LATENCY(1), .DEPTH_LOG2(DEPTH_LOG2)) dut1 (
    .clk(clk), .rst(rst[1]), .req_en(reqEn[1]), .req_wr(reqWr[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .ready(ready[1]), .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]),
    .dbgState(dbgState[1])
  );

  // One clock on instance u with the given inputs, then model update and checks.
  task automatic cycle(input int u, input logic r, input logic en, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdata);
    logic        expReady, expValid, chkData;
    logic [15:0] expRdata;
    int          key;
    rst[u] = r; reqEn[u] = en; reqWr[u] = wr; reqAddr[u] = addr; reqWdata[u] = wdata;
    @(posedge clk);
    if (r) begin
      sinceAcc[u] = 0;
    end else if (sinceAcc[u] == 0) begin
      if (en) begin
        sinceAcc[u] = 1;
        pWr[u]   = wr;
        pIdx[u]  = (int'(addr) >> 1) % (1 << DEPTH_LOG2);
        pData[u] = wdata;
      end
    end else begin
      sinceAcc[u] = sinceAcc[u] + 1;
      if (sinceAcc[u] > lat[u]) sinceAcc[u] = 0;
    end
    expReady = (sinceAcc[u] == 0);
    expValid = (sinceAcc[u] == lat[u]);
    expRdata = 16'h0000;
    chkData  = 1'b1;
    if (expValid) begin
      key = u * 65536 + pIdx[u];
      if (pWr[u]) modelMem[key] = pData[u];
      else if (modelMem.exists(key)) expRdata = modelMem[key];
      else chkData = 1'b0;
    end
    #1;
    nAsserts++;
    assert (ready[u] === expReady) else begin
      nFails++;
      $error("FAIL ready u=%0d t=%0t got %b exp %b", u, $time, ready[u], expReady);
    end
    nAsserts++;
    assert (rspValid[u] === expValid) else begin
      nFails++;
      $error("FAIL rsp_valid u=%0d t=%0t got %b exp %b", u, $time, rspValid[u], expValid);
    end
    if (chkData) begin
      nAsserts++;
      assert (rspRdata[u] === expRdata) else begin
        nFails++;
        $error("FAIL rsp_rdata u=%0d t=%0t got %h exp %h", u, $time, rspRdata[u], expRdata);
      end
    end
    nAsserts++;
    assert (!$isunknown(dbgState[u])) else begin
      nFails++;
      $error("FAIL dbg_state u=%0d t=%0t got %b exp known", u, $time, dbgState[u]);
    end
  endtask

  task automatic idle(input int u, input int n);
    for (int i = 0; i < n; i++) cycle(u, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic access(input int u, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata);
    cycle(u, 1'b0, 1'b1, wr, addr, wdata);
    idle(u, lat[u]);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; reqEn[u] = 1'b0; reqWr[u] = 1'b0;
      reqAddr[u] = 16'h0000; reqWdata[u] = 16'h0000; sinceAcc[u] = 0;
    end
    // reset both instances, including a request presented under reset
    for (int u = 0; u < 2; u++) begin
      cycle(u, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      cycle(u, 1'b1, 1'b1, 1'b1, 16'h0004, 16'h7777);
      idle(u, 1);
    end

    // known contents for small words and word 0x10
    for (int w = 0; w < 8; w++) access(0, 1'b1, 16'(w * 2), 16'($urandom));
    access(0, 1'b1, 16'h0020, 16'hCAFE);

    // write then read with addr[0] set
    access(0, 1'b1, 16'h0010, 16'hBEEF);
    access(0, 1'b0, 16'h0011, 16'h0000);

    // held req_en with alternating address/data: dropped requests have no effect
    for (int i = 0; i < 20; i++)
      cycle(0, 1'b0, 1'b1, 1'b0, (i % 2) ? 16'h0010 : 16'h0020, 16'($urandom));
    idle(0, 5);

    // reset two cycles after accepting a write aborts it
    cycle(0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234);
    idle(0, 1);
    cycle(0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    idle(0, 2);
    access(0, 1'b0, 16'h0020, 16'h0000);

    // request with reset in the same cycle is dropped
    cycle(0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h9999);
    access(0, 1'b0, 16'h0010, 16'h0000);

    // upper address bits alias
    access(0, 1'b1, 16'h0802, 16'h5A5A);
    access(0, 1'b0, 16'h0002, 16'h0000);

    // random traffic with in-flight input changes and occasional reset
    for (int i = 0; i < 400; i++)
      cycle(0, 1'b0 | ($urandom_range(0, 39) == 0), $urandom_range(0, 2) != 0,
            1'($urandom_range(0, 1)),
            16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1)),
            16'($urandom));
    idle(0, 5);

    // LATENCY=1 instance: write, then back-to-back held reads
    access(1, 1'b1, 16'h0040, 16'hA5C3);
    for (int w = 0; w < 8; w++) access(1, 1'b1, 16'(w * 2), 16'($urandom));
    for (int i = 0; i < 10; i++) cycle(1, 1'b0, 1'b1, 1'b0, (i % 2) ? 16'h0041 : 16'h0002, 16'h0000);
    for (int i = 0; i < 150; i++)
      cycle(1, 1'b0 | ($urandom_range(0, 39) == 0), $urandom_range(0, 2) != 0,
            1'($urandom_range(0, 1)),
            16'(($urandom_range(0, 31) << 11) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1)),
            16'($urandom));
    idle(1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
